// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified memory responder.
// Holds the FSM state encoding and the address legality check.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int MAX_AW = 64;

    // Word-aligned and inside the array; addr is zero-extended by the caller.
    function automatic logic addr_ok(
        input logic [MAX_AW-1:0] addr,
        input int unsigned       depth
    );
        logic [MAX_AW-1:0] idx;
        idx = addr >> 2;
        return (addr[1:0] == 2'b00) && (idx < MAX_AW'(depth));
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with byte-write mask.
// Read register clears on reset or on a rejected read.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IW    = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IW-1:0]     addr_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              clr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Unified I/D memory responder: one request at a time, fixed wait states.
// Optional byte-enabled writes when MEMRESP_BYTE_EN_EN is defined.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
`ifdef MEMRESP_BYTE_EN_EN
    input  logic [BE_W-1:0]   be,
`endif
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = 4;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q;

    logic              cap;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_we;
    logic              ok_q, ok_cur;
    logic              rd_go, wr_en;
    logic [IW-1:0]     ram_idx;

    assign cap      = (state_q == IDLE) && req;
    assign cur_addr = cap ? addr : addr_q;
    assign cur_we   = cap ? we : we_q;
    assign ok_q     = addr_ok(MAX_AW'(addr_q), DEPTH_WORDS);
    assign ok_cur   = addr_ok(MAX_AW'(cur_addr), DEPTH_WORDS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MEMRESP_BYTE_EN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            be_q <= '0;
        end else if (cap) begin
            be_q <= be;
        end
    end
`else
    assign be_q = '1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    cnt_d   = CW'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reads land in the RAM register on the edge entering RESP;
    // writes commit on the edge leaving it, so the port never collides.
    assign rd_go   = (state_d == RESP) && (state_q != RESP) && !cur_we;
    assign wr_en   = (state_q == RESP) && we_q && ok_q;
    assign ram_idx = wr_en ? addr_q[IW+1:2] : cur_addr[IW+1:2];

    always_comb begin
        ready = (state_q == RESP);
        err   = (state_q == RESP) && !ok_q;
        busy  = (state_q != IDLE);
    end

    mem_array #(
        .DEPTH (DEPTH_WORDS),
        .IW    (IW)
    ) u_array (
        .clk_i   (clk),
        .rst_ni  (reset),
        .addr_i  (ram_idx),
        .we_i    (wr_en),
        .be_i    (be_q),
        .wdata_i (wdata_q),
        .re_i    (rd_go && ok_cur),
        .clr_i   (rd_go && !ok_cur),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model plus directed cases.
// Second instance with zero wait states covers the fast path.
module tb_mem_responder;

    localparam int W = 2;
    localparam int D = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be_v = 4'hF;
    logic [31:0] rdata;
    logic        ready, err, busy;

    logic        req0 = 1'b0;
    logic        we0 = 1'b0;
    logic [31:0] addr0 = '0;
    logic [31:0] wdata0 = '0;
    logic [3:0]  be0 = 4'hF;
    logic [31:0] rdata0;
    logic        ready0, err0, busy0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(D), .WAIT_STATES(W), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
`ifdef MEMRESP_BYTE_EN_EN
        .be    (be_v),
`endif
        .rdata (rdata),
        .ready (ready),
        .err   (err),
        .busy  (busy)
    );

    mem_responder #(.DEPTH_WORDS(D), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .we    (we0),
        .addr  (addr0),
        .wdata (wdata0),
`ifdef MEMRESP_BYTE_EN_EN
        .be    (be0),
`endif
        .rdata (rdata0),
        .ready (ready0),
        .err   (err0),
        .busy  (busy0)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: accepted requests, completion cycle, memory image.
    logic [31:0] mem_m [D];
    bit          pend = 1'b0;
    int          resp_c = 0;
    int          idle_from = 0;
    logic        m_we;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;
    logic [31:0] rd_exp = '0;
    bit          r_exp;

    function automatic bit ok_m(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < D);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ready", 32'(ready), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_rdata", rdata, 0);
            pend = 1'b0;
            rd_exp = '0;
            idle_from = cyc;
        end else begin
            r_exp = pend && (cyc == resp_c);
            chk("ready", 32'(ready), 32'(r_exp));
            chk("busy", 32'(busy), 32'(pend));
            chk("err", 32'(err), 32'(r_exp && !ok_m(m_addr)));
            if (r_exp) begin
                if (!m_we) begin
                    rd_exp = ok_m(m_addr) ? mem_m[m_addr / 4] : 32'h0;
                end else if (ok_m(m_addr)) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[b]) mem_m[m_addr / 4][8*b +: 8] = m_wd[8*b +: 8];
                end
                pend = 1'b0;
            end
            chk("rdata", rdata, rd_exp);
            if (!pend && cyc >= idle_from && req) begin
                pend = 1'b1;
                resp_c = cyc + 1 + W;
                idle_from = resp_c + 1;
                m_we = we;
                m_addr = addr;
                m_wd = wdata;
                m_be = be_v;
            end
        end
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
        @(posedge clk); #2;
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = -1; rd = 'x; e = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready) begin
                lat = k - 1; rd = rdata; e = err;
                break;
            end
        end
        @(posedge clk); #2;
        req = 1'b0;
    endtask

    task automatic txn0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd,
                        output logic e, output int lat);
        @(posedge clk); #2;
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
        lat = -1; rd = 'x; e = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready0) begin
                lat = k - 1; rd = rdata0; e = err0;
                break;
            end
        end
        @(posedge clk); #2;
        req0 = 1'b0;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          nrdy;
    logic [31:0] hrd [2];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        txn(1'b1, 32'h0, 32'h01020304, rd, e, lat);
        chk("w0_err", 32'(e), 0);
        txn(1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat);
        chk("w10_lat", lat, 3);
        chk("w10_err", 32'(e), 0);
        txn(1'b0, 32'h10, 32'h0, rd, e, lat);
        chk("r10_lat", lat, 3);
        chk("r10_data", rd, 32'hDEADBEEF);

        txn(1'b0, 32'h12, 32'h0, rd, e, lat);
        chk("r12_err", 32'(e), 1);
        chk("r12_data", rd, 0);
        txn(1'b1, 32'h12, 32'h1234, rd, e, lat);
        chk("w12_err", 32'(e), 1);
        chk("w12_data", rd, 0);
        txn(1'b0, 32'h10, 32'h0, rd, e, lat);
        chk("r10b_data", rd, 32'hDEADBEEF);

        txn(1'b1, 32'h100, 32'h77777777, rd, e, lat);
        chk("w100_err", 32'(e), 1);
        txn(1'b0, 32'h0, 32'h0, rd, e, lat);
        chk("r0_data", rd, 32'h01020304);

        txn(1'b1, 32'hFC, 32'hA5A5_0F0F, rd, e, lat);
        chk("wFC_err", 32'(e), 0);
        txn(1'b0, 32'hFC, 32'h0, rd, e, lat);
        chk("rFC_data", rd, 32'hA5A5_0F0F);
        txn(1'b1, 32'h20, 32'h55AA55AA, rd, e, lat);

        // req held high while addr wanders; only captured addresses count
        nrdy = 0;
        @(posedge clk); #2;
        req = 1'b1; we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk); #2;
            end
            addr = (i == 0) ? 32'h10 : (i == 4) ? 32'h0 : 32'h104;
            @(negedge clk);
            if (ready) begin
                if (nrdy < 2) hrd[nrdy] = rdata;
                nrdy++;
            end
        end
        @(posedge clk); #2;
        req = 1'b0;
        chk("held_count", nrdy, 2);
        chk("held_rd0", hrd[0], 32'hDEADBEEF);
        chk("held_rd1", hrd[1], 32'h01020304);

        // reset during WAIT drops the pending write
        @(posedge clk); #2;
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
        @(posedge clk); #2;
        chk("pre_rst_busy", 32'(busy), 1);
        reset = 1'b0;
        req = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_ready", 32'(ready), 0);
        chk("async_rdata", rdata, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        txn(1'b0, 32'h20, 32'h0, rd, e, lat);
        chk("r20_data", rd, 32'h55AA55AA);

        txn0(1'b1, 32'h8, 32'h11223344, 4'hF, rd, e, lat);
        chk("z_w_lat", lat, 1);
        txn0(1'b0, 32'h8, 32'h0, 4'hF, rd, e, lat);
        chk("z_r_lat", lat, 1);
        chk("z_r_data", rd, 32'h11223344);
`ifdef MEMRESP_BYTE_EN_EN
        txn0(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rd, e, lat);
        txn0(1'b0, 32'h8, 32'h0, 4'b0000, rd, e, lat);
        chk("z_be_data", rd, 32'h11BB33DD);
        txn0(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, rd, e, lat);
        chk("z_be0_err", 32'(e), 0);
        txn0(1'b0, 32'h8, 32'h0, 4'hF, rd, e, lat);
        chk("z_be0_data", rd, 32'h11BB33DD);
`else
        txn0(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rd, e, lat);
        txn0(1'b0, 32'h8, 32'h0, 4'hF, rd, e, lat);
        chk("z_full_data", rd, 32'hAABBCCDD);
`endif
        txn0(1'b0, 32'h102, 32'h0, 4'hF, rd, e, lat);
        chk("z_bad_err", 32'(e), 1);
        chk("z_bad_data", rd, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
